// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - two-phase scan chain write sequencer for texture memory loads
// Frame per word is {start 0, addr MSB-first, data MSB-first}, one phi1/phi2 pair per bit, then a write strobe.
module scan_chain_loader #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int PHI_HALF = 1,
  parameter int DEPTH    = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              clear_count,
  output logic              phi1,
  output logic              phi2,
  output logic              scan_out,
  output logic              scan_wr,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done
);

  localparam int N  = 1 + ADDR_W + DATA_W;
  localparam int IW = $clog2(N);
  localparam logic [3:0]      PH_LAST = 4'(PHI_HALF - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, PH1, PH2, WRITE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      ph_q, ph_d;
  logic            so_d;
  logic [ADDR_W:0] cnt_d;
  logic            done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    so_d    = scan_out;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          shift_d = {1'b0, req_addr, req_data};
          idx_d   = IW'(N - 1);
          so_d    = shift_d[N-1];
          state_d = SETUP;
        end
      end
      SETUP: begin
        ph_d    = '0;
        state_d = PH1;
      end
      PH1: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = PH2;
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      PH2: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (idx_q == '0) begin
            state_d = WRITE;
          end else begin
            // scan_out only moves here, on the way back into SETUP
            shift_d = shift_q << 1;
            idx_d   = idx_q - 1'b1;
            so_d    = shift_d[N-1];
            state_d = SETUP;
          end
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over the increment of a coinciding WRITE.
  always_comb begin
    cnt_d  = word_count;
    done_d = load_done;
    if (clear_count) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (state_q == WRITE && word_count < DEPTH_C) begin
      cnt_d = word_count + 1'b1;
      if (word_count == DEPTH_C - 1'b1) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      ph_q       <= '0;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      scan_out   <= 1'b0;
      scan_wr    <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      word_count <= '0;
      load_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      ph_q       <= ph_d;
      phi1       <= (state_d == PH1);
      phi2       <= (state_d == PH2);
      scan_out   <= so_d;
      scan_wr    <= (state_d == WRITE);
      busy       <= (state_d != IDLE);
      req_ready  <= (state_d == IDLE);
      word_count <= cnt_d;
      load_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - bench for scan_chain_loader, default and PHI_HALF=3 builds
// Expected waveforms come from slot/offset arithmetic on the frame bits.
module tb_scan_chain_loader;
  localparam int N  = 20;
  localparam int D0 = 6;
  localparam int P3 = 3;
  localparam int S0 = 3;
  localparam int S3 = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst3 = 1'b1;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic        clear_count = 1'b0, clear_count3 = 1'b0;
  logic [10:0] req_addr = '0, req_addr3 = '0;
  logic [7:0]  req_data = '0, req_data3 = '0;
  logic        rdy0, p1_0, p2_0, so0, wr0, busy0, done0;
  logic        rdy3, p1_3, p2_3, so3, wr3, busy3, done3;
  logic [11:0] wc0, wc3;

  scan_chain_loader #(.ADDR_W(11), .DATA_W(8), .PHI_HALF(1), .DEPTH(D0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_addr(req_addr),
    .req_data(req_data), .clear_count(clear_count), .phi1(p1_0), .phi2(p2_0), .scan_out(so0),
    .scan_wr(wr0), .busy(busy0), .word_count(wc0), .load_done(done0));

  scan_chain_loader #(.ADDR_W(11), .DATA_W(8), .PHI_HALF(P3), .DEPTH(2048)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(rdy3), .req_addr(req_addr3),
    .req_data(req_data3), .clear_count(clear_count3), .phi1(p1_3), .phi2(p2_3), .scan_out(so3),
    .scan_wr(wr3), .busy(busy3), .word_count(wc3), .load_done(done3));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // {req_ready, busy, phi1, phi2, scan_out, scan_wr} for cycle rel after an accept (rel<1: idle)
  function automatic logic [5:0] expv(int rel, logic [19:0] fr, int p, logic so_idle);
    int s, slot, off;
    s = 1 + 2 * p;
    if (rel < 1) return {1'b1, 1'b0, 1'b0, 1'b0, so_idle, 1'b0};
    if (rel <= N * s) begin
      slot = (rel - 1) / s;
      off  = (rel - 1) % s;
      return {1'b0, 1'b1, (off >= 1 && off <= p), (off > p), fr[N-1-slot], 1'b0};
    end
    return {1'b0, 1'b1, 1'b0, 1'b0, fr[0], 1'b1};
  endfunction

  int m0_t = -1, m0_old, m0_cnt = 0;
  logic [19:0] m0_fr = '0;
  logic m0_so = 1'b0, m0_done = 1'b0;
  int acc0[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_t = -1; m0_cnt = 0; m0_done = 1'b0; m0_so = 1'b0;
    end else begin
      m0_old = m0_t;
      if (m0_old == -1) begin
        if (req_valid) begin
          m0_t = 1; m0_fr = {1'b0, req_addr, req_data}; acc0.push_back(cyc);
        end
      end else begin
        m0_t = m0_old + 1;
        if (m0_t == N * S0 + 2) begin m0_t = -1; m0_so = m0_fr[0]; end
      end
      if (clear_count) begin
        m0_cnt = 0; m0_done = 1'b0;
      end else if (m0_old == N * S0 + 1 && m0_cnt < D0) begin
        m0_cnt++;
        if (m0_cnt == D0) m0_done = 1'b1;
      end
    end
  end

  int m3_t = -1, m3_old, acc3 = 0, acc3_n = 0;
  logic [19:0] m3_fr = '0;
  logic m3_so = 1'b0;
  always @(posedge clk or posedge rst3) begin
    if (rst3) begin
      m3_t = -1; m3_so = 1'b0;
    end else begin
      m3_old = m3_t;
      if (m3_old == -1) begin
        if (req_valid3) begin
          m3_t = 1; m3_fr = {1'b0, req_addr3, req_data3}; acc3 = cyc; acc3_n++;
        end
      end else begin
        m3_t = m3_old + 1;
        if (m3_t == N * S3 + 2) begin m3_t = -1; m3_so = m3_fr[0]; end
      end
    end
  end

  logic [19:0] cap0 = '0, cap3 = '0;
  logic p1_0_prev = 1'b0, p1_3_prev = 1'b0, rdy0_prev = 1'b1, done0_prev = 1'b0;
  int wr0_cyc = 0, wr0_n = 0, wr3_cyc = 0, ph3_n = 0, rdy0_rise = 0, done0_rise = 0;
  always @(posedge clk) begin
    #1;
    chk("cycle_dut", 32'({rdy0, busy0, p1_0, p2_0, so0, wr0, done0, wc0}),
        32'({expv(m0_t, m0_fr, 1, m0_so), m0_done, 12'(m0_cnt)}));
    chk("cycle_dut3", 32'({rdy3, busy3, p1_3, p2_3, so3, wr3}), 32'(expv(m3_t, m3_fr, P3, m3_so)));
    chk("phi_overlap", 32'({p1_0 & p2_0, p1_3 & p2_3}), 32'd0);
    assert (!(p1_3 && p2_3));
    if (p1_0 && !p1_0_prev) cap0 = {cap0[18:0], so0};
    if (p1_3 && !p1_3_prev) cap3 = {cap3[18:0], so3};
    if (p1_3) ph3_n++;
    if (wr0) begin wr0_cyc = cyc; wr0_n++; end
    if (wr3) wr3_cyc = cyc;
    if (rdy0 && !rdy0_prev) rdy0_rise = cyc;
    if (done0 && !done0_prev) done0_rise = cyc;
    p1_0_prev = p1_0; p1_3_prev = p1_3; rdy0_prev = rdy0; done0_prev = done0;
  end

  task automatic wait_acc0(input int n);
    int i;
    for (i = 0; i < 300 && acc0.size() == n; i++) @(negedge clk);
    if (acc0.size() == n) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send0(input logic [10:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    n = acc0.size();
    wait_acc0(n);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int i;
    for (i = 0; i < 300 && !rdy0; i++) @(negedge clk);
    if (!rdy0) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n, i, w0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({rdy0, busy0, p1_0, p2_0, so0, wr0, done0, wc0}), 32'h40000);
    chk("reset_outputs3", 32'({rdy3, busy3, p1_3, p2_3, so3, wr3}), 32'h20);
    @(negedge clk);
    rst = 1'b0; rst3 = 1'b0;

    // PHI_HALF=3 build
    @(negedge clk);
    req_valid3 = 1'b1; req_addr3 = 11'h7FF; req_data3 = 8'hFF;
    for (i = 0; i < 50 && acc3_n == 0; i++) @(negedge clk);
    req_valid3 = 1'b0;
    for (i = 0; i < 300 && !rdy3; i++) @(negedge clk);
    @(negedge clk);
    chk("p3_wr_latency", 32'(wr3_cyc - acc3), 32'd141);
    chk("p3_bits", 32'(cap3), 32'h7FFFF);
    chk("p3_phi1_width", 32'(ph3_n), 32'd60);
    chk("p3_count", 32'(wc3), 32'd1);

    // asynchronous reset between edges
    send0(11'h2AA, 8'h55);
    repeat (4) @(negedge clk);
    chk("busy_before_rst", 32'(busy0), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'({rdy0, busy0, p1_0, p2_0, so0, wr0, done0, wc0}), 32'h40000);
    @(negedge clk);
    rst = 1'b0;

    // single word
    cap0 = '0;
    send0(11'h005, 8'hA5);
    wait_idle0();
    chk("single_wr_latency", 32'(wr0_cyc - acc0[$]), 32'd61);
    chk("single_ready_back", 32'(rdy0_rise - acc0[$]), 32'd62);
    chk("single_bits", 32'(cap0), 32'h005A5);
    chk("single_count", 32'(wc0), 32'd1);

    // back-to-back with valid held
    w0 = wr0_n;
    n = acc0.size();
    @(negedge clk);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = 11'(11'h100 + k); req_data = 8'(8'h10 + k);
      wait_acc0(n + k);
    end
    req_valid = 1'b0;
    wait_idle0();
    chk("b2b_wr_pulses", 32'(wr0_n - w0), 32'd3);
    chk("b2b_spacing_1", 32'(acc0[n+1] - acc0[n]), 32'd62);
    chk("b2b_spacing_2", 32'(acc0[n+2] - acc0[n+1]), 32'd62);
    chk("b2b_count", 32'(wc0), 32'd4);

    // reset during PH1 of bit 7 (data MSB, slot 12, cycle 38)
    send0(11'h123, 8'hDC);
    for (i = 0; i < 100 && cyc < acc0[$] + 38; i++) begin @(posedge clk); #2; end
    chk("ph1_bit7", 32'({p1_0, p2_0, so0}), 32'h5);
    w0 = wr0_n;
    rst = 1'b1;
    #1 chk("midword_rst", 32'({rdy0, busy0, p1_0, p2_0, so0, wr0, done0, wc0}), 32'h40000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    chk("midword_no_wr", 32'(wr0_n - w0), 32'd0);
    chk("midword_count", 32'(wc0), 32'd0);
    cap0 = '0;
    send0(11'h7A0, 8'h3C);
    wait_idle0();
    chk("after_rst_bits", 32'(cap0), 32'h7A03C);
    chk("after_rst_count", 32'(wc0), 32'd1);

    // fill to DEPTH, saturate, then clear on a WRITE
    for (int k = 0; k < 4; k++) begin send0(11'(k), 8'(k)); wait_idle0(); end
    chk("pre_full", 32'({done0, wc0}), 32'd5);
    send0(11'h7FE, 8'h01);
    wait_idle0();
    chk("full_count", 32'({done0, wc0}), 32'h1006);
    chk("done_edge", 32'(done0_rise - wr0_cyc), 32'd1);
    send0(11'h7FF, 8'h02);
    wait_idle0();
    chk("saturate", 32'({done0, wc0}), 32'h1006);
    send0(11'h001, 8'h03);
    for (i = 0; i < 100 && !wr0; i++) begin @(posedge clk); #2; end
    clear_count = 1'b1;
    @(posedge clk); #2;
    clear_count = 1'b0;
    wait_idle0();
    chk("clear_on_write", 32'({done0, wc0}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
